soc_bus_arbiter: RTL and testbench

Two-master arbiter that sits directly upstream of the SoC interconnect. It merges the CPU instruction-fetch port (read-only) and data port (read/write) onto the single interconnect master port. It forwards the granted command, honours interconnect `waitRequest`, and tracks outstanding reads in an ordered owner FIFO so each `readValid` beat is routed back to the master that issued it.

---
 rtl/soc_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_soc_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single interconnect master port.
// Outstanding reads are tracked in an in-order owner FIFO that routes each readValid beat back to its master.
module soc_bus_arbiter #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instAddress,
  input  logic        instRead,
  output logic        instWaitRequest,
  output logic        instReadValid,
  output logic [31:0] instReadData,
  input  logic [31:0] dataAddress,
  input  logic        dataRead,
  input  logic        dataWrite,
  input  logic [31:0] dataWriteData,
  output logic        dataWaitRequest,
  output logic        dataReadValid,
  output logic [31:0] dataReadData,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writeData,
  input  logic        waitRequest,
  input  logic        readValid,
  input  logic [31:0] dataIn,
  output logic        spuriousValid
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;

  logic [MAX_PENDING-1:0] r_fifo;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_last_grant;
  logic                   r_lock_valid;
  logic                   r_lock_owner;
  logic                   r_spurious;

  logic w_full;
  logic w_empty;
  logic w_inst_elig;
  logic w_data_elig;
  logic w_grant_valid;
  logic w_grant_owner;
  logic w_grant_is_read;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_count == CNT_W'(MAX_PENDING));
  assign w_empty = (r_count == '0);

  // A full owner FIFO blocks reads only; writes still pass. Full is judged on the
  // registered count so readValid never reaches waitRequest combinationally.
  assign w_inst_elig = instRead & ~w_full;
  assign w_data_elig = dataWrite | (dataRead & ~w_full);

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_owner = 1'b0;
    if (r_lock_valid && (r_lock_owner ? w_data_elig : w_inst_elig)) begin
      w_grant_valid = 1'b1;
      w_grant_owner = r_lock_owner;
    end else if (w_inst_elig && w_data_elig) begin
      w_grant_valid = 1'b1;
      w_grant_owner = ~r_last_grant;
    end else if (w_inst_elig) begin
      w_grant_valid = 1'b1;
      w_grant_owner = 1'b0;
    end else if (w_data_elig) begin
      w_grant_valid = 1'b1;
      w_grant_owner = 1'b1;
    end
  end

  always_comb begin
    address = '0;
    read    = 1'b0;
    write   = 1'b0;
    if (w_grant_valid) begin
      if (w_grant_owner) begin
        address = dataAddress;
        read    = dataRead;
        write   = dataWrite;
      end else begin
        address = instAddress;
        read    = instRead;
      end
    end
  end

  assign writeData       = dataWriteData;
  assign w_grant_is_read = read;
  assign w_accept        = w_grant_valid & ~waitRequest;
  assign w_push          = w_accept & w_grant_is_read;
  assign w_pop           = readValid & ~w_empty;
  assign w_head          = r_fifo[r_rd_ptr];

  assign instWaitRequest = instRead & ~(w_grant_valid & ~w_grant_owner & ~waitRequest);
  assign dataWaitRequest = (dataRead | dataWrite) & ~(w_grant_valid & w_grant_owner & ~waitRequest);

  assign instReadValid = w_pop & ~w_head;
  assign dataReadValid = w_pop & w_head;
  assign instReadData  = dataIn;
  assign dataReadData  = dataIn;
  assign spuriousValid = r_spurious;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_grant_owner;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b0;
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_spurious   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_owner;
        r_lock_valid <= 1'b0;
      end else if (w_grant_valid) begin
        r_lock_valid <= 1'b1;
        r_lock_owner <= w_grant_owner;
      end
      if (readValid && w_empty) begin
        r_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter: arbitration, stall lock, full blocking,
// response ordering, spurious responses and reset mid-transaction.
module tb_soc_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] instAddress;
  logic        instRead;
  logic        instWaitRequest;
  logic        instReadValid;
  logic [31:0] instReadData;
  logic [31:0] dataAddress;
  logic        dataRead;
  logic        dataWrite;
  logic [31:0] dataWriteData;
  logic        dataWaitRequest;
  logic        dataReadValid;
  logic [31:0] dataReadData;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writeData;
  logic        waitRequest;
  logic        readValid;
  logic [31:0] dataIn;
  logic        spuriousValid;

  int errors = 0;
  int checks = 0;

  soc_bus_arbiter #(.MAX_PENDING(4)) dut (
    .clk(clk), .reset(reset),
    .instAddress(instAddress), .instRead(instRead), .instWaitRequest(instWaitRequest),
    .instReadValid(instReadValid), .instReadData(instReadData),
    .dataAddress(dataAddress), .dataRead(dataRead), .dataWrite(dataWrite),
    .dataWriteData(dataWriteData), .dataWaitRequest(dataWaitRequest),
    .dataReadValid(dataReadValid), .dataReadData(dataReadData),
    .address(address), .read(read), .write(write), .writeData(writeData),
    .waitRequest(waitRequest), .readValid(readValid), .dataIn(dataIn),
    .spuriousValid(spuriousValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    instAddress = 32'h0; instRead = 1'b0;
    dataAddress = 32'h0; dataRead = 1'b0; dataWrite = 1'b0; dataWriteData = 32'h0;
    waitRequest = 1'b0; readValid = 1'b0; dataIn = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++;
    if ({read, write, address} !== 33'h0) begin
      errors++; $display("FAIL reset_cmd got read=%b write=%b addr=%h want 0", read, write, address);
    end
    checks++;
    if ({instWaitRequest, dataWaitRequest, instReadValid, dataReadValid, spuriousValid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_status got iwr=%b dwr=%b irv=%b drv=%b sp=%b want 0",
               instWaitRequest, dataWaitRequest, instReadValid, dataReadValid, spuriousValid);
    end
    checks++;
    if ({writeData, instReadData, dataReadData} !== 96'h0) begin
      errors++; $display("FAIL reset_data got wd=%h ird=%h drd=%h want 0", writeData, instReadData, dataReadData);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_owner;
    logic prev_owner;
    do_reset();
    instAddress = 32'h0000_1000; dataAddress = 32'h0000_2000;
    instRead = 1'b1; dataRead = 1'b1;
    prev_owner = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_owner = (i % 2 == 0);
      readValid = (i > 0);
      dataIn = 32'hA0 + i;
      #2;
      checks++;
      if (read !== 1'b1 || address !== (exp_owner ? 32'h2000 : 32'h1000)) begin
        errors++; $display("FAIL rr_grant cyc=%0d got read=%b addr=%h want owner=%0d", i, read, address, exp_owner);
      end
      checks++;
      if (instWaitRequest !== exp_owner || dataWaitRequest !== ~exp_owner) begin
        errors++; $display("FAIL rr_wait cyc=%0d got iwr=%b dwr=%b want iwr=%b dwr=%b",
                           i, instWaitRequest, dataWaitRequest, exp_owner, ~exp_owner);
      end
      if (i > 0) begin
        checks++;
        if (instReadValid !== ~prev_owner || dataReadValid !== prev_owner || instReadData !== (32'hA0 + i)) begin
          errors++; $display("FAIL rr_resp cyc=%0d got irv=%b drv=%b ird=%h want owner=%0d data=%h",
                             i, instReadValid, dataReadValid, instReadData, prev_owner, 32'hA0 + i);
        end
      end
      prev_owner = exp_owner;
      tick();
    end
    instRead = 1'b0; dataRead = 1'b0; readValid = 1'b1; dataIn = 32'hBB;
    #2;
    checks++;
    if (instReadValid !== 1'b1 || dataReadValid !== 1'b0 || read !== 1'b0) begin
      errors++; $display("FAIL rr_last got irv=%b drv=%b read=%b want 1 0 0", instReadValid, dataReadValid, read);
    end
    tick();
    readValid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    instAddress = 32'h0000_0040; dataAddress = 32'h0000_0080; dataWriteData = 32'hCAFE_0001;
    instRead = 1'b1; waitRequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dataWrite = (i > 0);
      #2;
      checks++;
      if (read !== 1'b1 || write !== 1'b0 || address !== 32'h40 || instWaitRequest !== 1'b1) begin
        errors++; $display("FAIL stall_hold cyc=%0d got read=%b write=%b addr=%h iwr=%b want 1 0 40 1",
                           i, read, write, address, instWaitRequest);
      end
      if (i > 0) begin
        checks++;
        if (dataWaitRequest !== 1'b1) begin
          errors++; $display("FAIL stall_dwait cyc=%0d got dwr=%b want 1", i, dataWaitRequest);
        end
      end
      tick();
    end
    waitRequest = 1'b0;
    #2;
    checks++;
    if (read !== 1'b1 || address !== 32'h40 || instWaitRequest !== 1'b0 || dataWaitRequest !== 1'b1) begin
      errors++; $display("FAIL stall_accept got read=%b addr=%h iwr=%b dwr=%b want 1 40 0 1",
                         read, address, instWaitRequest, dataWaitRequest);
    end
    tick();
    instRead = 1'b0;
    #2;
    checks++;
    if (write !== 1'b1 || read !== 1'b0 || address !== 32'h80 || writeData !== 32'hCAFE_0001 || dataWaitRequest !== 1'b0) begin
      errors++; $display("FAIL stall_data got write=%b read=%b addr=%h wd=%h dwr=%b want 1 0 80 cafe0001 0",
                         write, read, address, writeData, dataWaitRequest);
    end
    tick();
    dataWrite = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    instRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instAddress = 32'h100 + 4 * i;
      #2;
      checks++;
      if (read !== 1'b1 || instWaitRequest !== 1'b0 || address !== (32'h100 + 4 * i)) begin
        errors++; $display("FAIL full_fill cyc=%0d got read=%b iwr=%b addr=%h want 1 0 %h",
                           i, read, instWaitRequest, address, 32'h100 + 4 * i);
      end
      tick();
    end
    instAddress = 32'h200; dataAddress = 32'h300; dataWrite = 1'b1; dataWriteData = 32'hDEAD;
    #2;
    checks++;
    if (instWaitRequest !== 1'b1 || read !== 1'b0 || write !== 1'b1 || dataWaitRequest !== 1'b0 || address !== 32'h300) begin
      errors++; $display("FAIL full_block got iwr=%b read=%b write=%b dwr=%b addr=%h want 1 0 1 0 300",
                         instWaitRequest, read, write, dataWaitRequest, address);
    end
    tick();
    dataWrite = 1'b0; readValid = 1'b1; dataIn = 32'h77;
    #2;
    checks++;
    if (instWaitRequest !== 1'b1 || read !== 1'b0 || instReadValid !== 1'b1 || dataReadValid !== 1'b0) begin
      errors++; $display("FAIL full_pop got iwr=%b read=%b irv=%b drv=%b want 1 0 1 0",
                         instWaitRequest, read, instReadValid, dataReadValid);
    end
    tick();
    readValid = 1'b0;
    #2;
    checks++;
    if (instWaitRequest !== 1'b0 || read !== 1'b1 || address !== 32'h200) begin
      errors++; $display("FAIL full_free got iwr=%b read=%b addr=%h want 0 1 200", instWaitRequest, read, address);
    end
    tick();
    instRead = 1'b0;
  endtask

  task automatic test_order();
    logic [31:0] vals [3];
    logic        own [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    own[0] = 1'b1; own[1] = 1'b0; own[2] = 1'b1;
    do_reset();
    dataRead = 1'b1; tick();
    dataRead = 1'b0; instRead = 1'b1; tick();
    instRead = 1'b0; dataRead = 1'b1; tick();
    dataRead = 1'b0;
    for (int i = 0; i < 3; i++) begin
      readValid = 1'b1; dataIn = vals[i];
      #2;
      checks++;
      if (dataReadValid !== own[i] || instReadValid !== ~own[i] ||
          (own[i] ? dataReadData : instReadData) !== vals[i]) begin
        errors++; $display("FAIL order_resp beat=%0d got drv=%b irv=%b drd=%h ird=%h want owner=%0d data=%h",
                           i, dataReadValid, instReadValid, dataReadData, instReadData, own[i], vals[i]);
      end
      tick();
    end
    readValid = 1'b0;
    checks++;
    if (spuriousValid !== 1'b0) begin
      errors++; $display("FAIL order_nospur got sp=%b want 0", spuriousValid);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    readValid = 1'b1; dataIn = 32'h55;
    #2;
    checks++;
    if (instReadValid !== 1'b0 || dataReadValid !== 1'b0) begin
      errors++; $display("FAIL spur_route got irv=%b drv=%b want 0 0", instReadValid, dataReadValid);
    end
    tick();
    readValid = 1'b0;
    checks++;
    if (spuriousValid !== 1'b1) begin
      errors++; $display("FAIL spur_set got sp=%b want 1", spuriousValid);
    end
    tick(); tick();
    checks++;
    if (spuriousValid !== 1'b1) begin
      errors++; $display("FAIL spur_sticky got sp=%b want 1", spuriousValid);
    end
    instRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (instWaitRequest !== 1'b0) begin
        errors++; $display("FAIL spur_count cyc=%0d got iwr=%b want 0", i, instWaitRequest);
      end
      tick();
    end
    #2;
    checks++;
    if (instWaitRequest !== 1'b1 || read !== 1'b0) begin
      errors++; $display("FAIL spur_full got iwr=%b read=%b want 1 0", instWaitRequest, read);
    end
    tick();
    instRead = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    instAddress = 32'h10; dataAddress = 32'h20;
    instRead = 1'b1; tick();
    instRead = 1'b0; dataRead = 1'b1; tick();
    dataRead = 1'b0; instRead = 1'b1; waitRequest = 1'b1;
    #2;
    checks++;
    if (instWaitRequest !== 1'b1 || read !== 1'b1 || address !== 32'h10) begin
      errors++; $display("FAIL mid_stall got iwr=%b read=%b addr=%h want 1 1 10", instWaitRequest, read, address);
    end
    tick();
    reset = 1'b1; dataRead = 1'b1;
    #2;
    checks++;
    if (read !== 1'b1 || address !== 32'h20 || spuriousValid !== 1'b0) begin
      errors++; $display("FAIL mid_lockclr got read=%b addr=%h sp=%b want 1 20 0", read, address, spuriousValid);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    readValid = 1'b1;
    #2;
    checks++;
    if (instReadValid !== 1'b0 || dataReadValid !== 1'b0) begin
      errors++; $display("FAIL mid_route got irv=%b drv=%b want 0 0", instReadValid, dataReadValid);
    end
    tick();
    readValid = 1'b0;
    checks++;
    if (spuriousValid !== 1'b1) begin
      errors++; $display("FAIL mid_spur got sp=%b want 1", spuriousValid);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_stall();
    test_full();
    test_order();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
